// File: rtl/tg_axi_mem_rsp_pkg.sv
// Shared encodings and FSM state types for the AXI4 memory responder.
package tg_axi_mem_rsp_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // True when a burst starting at word and spanning len+1 beats runs past the top of a 2^aw RAM.
    function automatic logic crosses_top(input int unsigned word, input int unsigned len,
                                         input int unsigned aw);
        return (word + len) >= (32'd1 << aw);
    endfunction

endpackage

// File: rtl/tg_axi_mem_rsp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered 1-cycle read port.
// A same-cycle read and write to one word returns the old contents.
module tg_axi_mem_rsp_ram #(
    parameter int AW = 10,
    parameter int DW = 512
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic [DW/8-1:0] i_wbe,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tg_axi_mem_responder.sv
// AXI4 memory responder with independent single-outstanding write and read paths.
// Define TG_AXI_MEM_RSP_DECERR_EN to reject bursts running past the RAM top with DECERR.
module tg_axi_mem_responder
    import tg_axi_mem_rsp_pkg::*;
#(
    parameter int ID_W   = 9,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512,
    parameter int USER_W = 8,
    parameter int MEM_AW = 10
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic [USER_W-1:0]   awuser,
    input  logic                awvalid,
    output logic                awready,

    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,

    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,

    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic [USER_W-1:0]   aruser,
    input  logic                arvalid,
    output logic                arready,

    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,

    output logic [31:0]         wr_beats,
    output logic [31:0]         rd_beats
);

    localparam int OFF = $clog2(DATA_W/8);

    logic [MEM_AW-1:0] w_aw_word, w_ar_word;
    logic              w_aw_err, w_ar_err;
    logic              w_unused_ok;

    assign w_aw_word   = awaddr[OFF +: MEM_AW];
    assign w_ar_word   = araddr[OFF +: MEM_AW];
    assign w_unused_ok = ^{awsize, awuser, arsize, aruser, awaddr, araddr};

`ifdef TG_AXI_MEM_RSP_DECERR_EN
    assign w_aw_err = crosses_top(32'(w_aw_word), 32'(awlen), MEM_AW);
    assign w_ar_err = crosses_top(32'(w_ar_word), 32'(arlen), MEM_AW);
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
`endif

    // ---------------- write path ----------------
    w_state_t          r_wstate;
    logic [ID_W-1:0]   r_bid;
    logic [7:0]        r_wlen, r_wcnt;
    logic [MEM_AW-1:0] r_waddr;
    logic [1:0]        r_wburst, r_bresp;
    logic              r_werr, r_wslv;
    logic              w_w_hs, w_wlast_beat, w_wlast_bad;

    assign awready      = (r_wstate == W_IDLE) && !rst;
    assign wready       = (r_wstate == W_DATA) && !rst;
    assign bvalid       = (r_wstate == W_RESP);
    assign bid          = r_bid;
    assign bresp        = r_bresp;
    assign w_w_hs       = wvalid && wready;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_wlast_bad  = (wlast != w_wlast_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_bid    <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_waddr  <= '0;
            r_wburst <= BURST_FIXED;
            r_werr   <= 1'b0;
            r_wslv   <= 1'b0;
            r_bresp  <= RESP_OKAY;
            wr_beats <= '0;
        end else begin
            if (w_w_hs) wr_beats <= wr_beats + 32'd1;
            case (r_wstate)
                W_IDLE: if (awvalid) begin
                    r_bid    <= awid;
                    r_wlen   <= awlen;
                    r_wcnt   <= '0;
                    r_waddr  <= w_aw_word;
                    r_wburst <= awburst;
                    r_werr   <= w_aw_err;
                    r_wslv   <= 1'b0;
                    r_wstate <= W_DATA;
                end
                W_DATA: if (w_w_hs) begin
                    r_wcnt <= r_wcnt + 8'd1;
                    if (r_wburst != BURST_FIXED) r_waddr <= r_waddr + MEM_AW'(1);
                    if (w_wlast_bad) r_wslv <= 1'b1;
                    // The beat count, not wlast, decides where the burst ends.
                    if (w_wlast_beat) begin
                        r_wstate <= W_RESP;
                        r_bresp  <= r_werr ? RESP_DECERR :
                                    (r_wslv || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                W_RESP: if (bready) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t          r_rstate;
    logic [ID_W-1:0]   r_rid;
    logic [7:0]        r_rlen;
    logic [8:0]        r_rcnt;
    logic [MEM_AW-1:0] r_raddr;
    logic [1:0]        r_rburst, r_rresp;
    logic              r_rerr, r_rstart, r_rvalid, r_rlast;
    logic              w_r_hs, w_rd_more, w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;

    assign arready   = (r_rstate == R_IDLE) && !rst;
    assign rvalid    = r_rvalid;
    assign rlast     = r_rlast;
    assign rid       = r_rid;
    assign rresp     = r_rresp;
    assign rdata     = r_rerr ? '0 : w_ram_rdata;
    assign w_r_hs    = r_rvalid && rready;
    assign w_rd_more = (r_rcnt <= {1'b0, r_rlen});
    // The RAM output register doubles as the R data holding register, so a
    // read is only issued when the current beat is absent or leaving.
    assign w_ram_re  = (r_rstate == R_DATA) && !r_rstart && w_rd_more && (!r_rvalid || rready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_raddr  <= '0;
            r_rburst <= BURST_FIXED;
            r_rerr   <= 1'b0;
            r_rstart <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rresp  <= RESP_OKAY;
            rd_beats <= '0;
        end else begin
            if (w_r_hs) rd_beats <= rd_beats + 32'd1;
            case (r_rstate)
                R_IDLE: if (arvalid) begin
                    r_rid    <= arid;
                    r_rlen   <= arlen;
                    r_rcnt   <= '0;
                    r_raddr  <= w_ar_word;
                    r_rburst <= arburst;
                    r_rerr   <= w_ar_err;
                    r_rresp  <= w_ar_err ? RESP_DECERR : RESP_OKAY;
                    r_rstart <= 1'b1;
                    r_rstate <= R_DATA;
                end
                R_DATA: begin
                    r_rstart <= 1'b0;
                    if (w_ram_re) begin
                        r_rcnt   <= r_rcnt + 9'd1;
                        if (r_rburst != BURST_FIXED) r_raddr <= r_raddr + MEM_AW'(1);
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_rcnt == {1'b0, r_rlen});
                    end else if (w_r_hs) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                    end
                    if (w_r_hs && r_rlast) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    tg_axi_mem_rsp_ram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_w_hs && !r_werr),
        .i_waddr (r_waddr),
        .i_wdata (wdata),
        .i_wbe   (wstrb),
        .i_re    (w_ram_re),
        .i_raddr (r_raddr),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_tg_axi_mem_responder.sv
// Directed bench for tg_axi_mem_responder: vector table of write/readback bursts
// plus hand-written strobe, out-of-range and reset-mid-burst sequences.
module tb_tg_axi_mem_responder;
    import tg_axi_mem_rsp_pkg::*;

    localparam int ID_W = 9, ADDR_W = 32, DATA_W = 512, USER_W = 8, MEM_AW = 10;
    localparam int SB = DATA_W/8, OFF = 6, DEPTH = 1 << MEM_AW;
`ifdef TG_AXI_MEM_RSP_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [ID_W-1:0] awid = '0, bid, arid = '0, rid;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0;
    logic [2:0] awsize = 3'd6, arsize = 3'd6;
    logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
    logic [USER_W-1:0] awuser = '0, aruser = '0;
    logic awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
    logic arvalid = 0, arready, rlast, rvalid, rready = 0;
    logic [DATA_W-1:0] wdata = '0, rdata;
    logic [SB-1:0] wstrb = '0;
    logic [31:0] wr_beats, rd_beats;

    tg_axi_mem_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                           .USER_W(USER_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .aruser(aruser), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int exp_wr = 0, exp_rd = 0;
    logic [DATA_W-1:0] mdl [0:DEPTH-1];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input logic [31:0] seed, input int beat);
        return {(DATA_W/32){seed + 32'(beat)}};
    endfunction

    function automatic bit is_err(input int word, input int len);
        return DEC && ((word + len) >= DEPTH);
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] addr, input int len, input logic [1:0] burst,
                            input logic [31:0] seed, input logic [SB-1:0] strb, input int lastb,
                            input logic [ID_W-1:0] id, output logic [1:0] resp, output logic [ID_W-1:0] id_o);
        int t, word;
        bit err;
        word = int'(addr >> OFF) % DEPTH;
        err  = is_err(word, len);
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("aw_timeout", 1'(t < 200), 1'b1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            wdata = pat(seed, b); wstrb = strb; wlast = (b == lastb); wvalid = 1'b1;
            t = 0;
            while (!wready && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) chk("w_timeout", 1'(t < 200), 1'b1);
            if (!err)
                for (int k = 0; k < SB; k++) if (strb[k]) mdl[word][k*8 +: 8] = wdata[k*8 +: 8];
            @(negedge clk);
            if (burst != BURST_FIXED) word = (word + 1) % DEPTH;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_wr += len + 1;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 200) begin @(negedge clk); t++; end
        chk("b_arrives", 1'(t < 200), 1'b1);
        resp = bresp; id_o = bid;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [ADDR_W-1:0] addr, input int len,
                           input logic [1:0] burst, input bit tog, input logic [ID_W-1:0] id,
                           output logic [DATA_W-1:0] d0);
        int t, word, beat, first;
        bit err, stall;
        logic [DATA_W-1:0] pd, exp;
        logic pl;
        word = int'(addr >> OFF) % DEPTH;
        err  = is_err(word, len);
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk({tag, "_ar_timeout"}, 1'(t < 200), 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        t = 0; beat = 0; first = -1; stall = 0; pd = '0; pl = 0; d0 = '0;
        while (beat <= len && t < 2000) begin
            rready = tog ? (t % 2 == 1) : 1'b1;
            if (rvalid && first < 0) first = t;
            if (stall) begin
                chk({tag, "_stall_data"}, rdata, pd);
                chk({tag, "_stall_last"}, rlast, pl);
            end
            if (rvalid && rready) begin
                exp = err ? '0 : mdl[word];
                if (beat == 0) d0 = rdata;
                chk($sformatf("%s_data%0d", tag, beat), rdata, exp);
                chk($sformatf("%s_last%0d", tag, beat), rlast, 1'(beat == len));
                chk($sformatf("%s_resp%0d", tag, beat), rresp, err ? RESP_DECERR : RESP_OKAY);
                chk($sformatf("%s_rid%0d", tag, beat), rid, id);
                beat++;
                if (burst != BURST_FIXED) word = (word + 1) % DEPTH;
            end
            stall = rvalid && !rready; pd = rdata; pl = rlast;
            @(negedge clk);
            t++;
        end
        rready = 1'b0;
        exp_rd += len + 1;
        chk({tag, "_latency"}, 32'(first), 32'd2);
        chk({tag, "_nbeats"}, 32'(beat), 32'(len + 1));
        chk({tag, "_rvalid_done"}, rvalid, 1'b0);
        chk({tag, "_rd_beats"}, rd_beats, 32'(exp_rd));
        chk({tag, "_wr_beats"}, wr_beats, 32'(exp_wr));
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                len;
        logic [1:0]        burst;
        logic [31:0]       seed;
        int                lastb;
        bit                tog;
        logic [1:0]        exp_b;
    } vec_t;

    vec_t vt [7];

    initial begin
        logic [1:0] r_b;
        logic [ID_W-1:0] r_id;
        logic [DATA_W-1:0] d0;
        int t, beats;
        bit seen;

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        vt[0] = '{32'h40,   0,  BURST_INCR,  32'hA5A5A5A5, 0,  1'b0, RESP_OKAY};
        vt[1] = '{32'h1000, 15, BURST_INCR,  32'h10000000, 15, 1'b1, RESP_OKAY};
        vt[2] = '{32'h2000, 3,  BURST_INCR,  32'h20000000, 1,  1'b0, RESP_SLVERR};
        vt[3] = '{32'h3000, 3,  BURST_FIXED, 32'h30000000, 3,  1'b0, RESP_OKAY};
        vt[4] = '{32'h4000, 7,  BURST_WRAP,  32'h40000000, 7,  1'b1, RESP_OKAY};
        vt[5] = '{32'h0,    1,  BURST_INCR,  32'h50000000, 1,  1'b0, RESP_OKAY};
        vt[6] = '{32'hFF80, 3,  BURST_INCR,  32'h60000000, 3,  1'b0, DEC ? RESP_DECERR : RESP_OKAY};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_rlast",   rlast,   1'b0);
        chk("rst_bresp",   bresp,   2'b00);
        chk("rst_rresp",   rresp,   2'b00);
        chk("rst_wr_beats", wr_beats, 32'd0);
        chk("rst_rd_beats", rd_beats, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        @(negedge clk);

        // Vector table: write burst, check B, read back against the reference memory
        for (int i = 0; i < 7; i++) begin
            do_write(vt[i].addr, vt[i].len, vt[i].burst, vt[i].seed, {SB{1'b1}}, vt[i].lastb,
                     ID_W'(i + 1), r_b, r_id);
            chk($sformatf("v%0d_bresp", i), r_b, vt[i].exp_b);
            chk($sformatf("v%0d_bid", i), r_id, ID_W'(i + 1));
            do_read($sformatf("v%0d", i), vt[i].addr, vt[i].len, vt[i].burst, vt[i].tog,
                    ID_W'(i + 100), d0);
            if (i == 0) chk("v0_a5_word", d0, {(DATA_W/8){8'hA5}});
            if (i == 3) chk("v3_fixed_last", d0, pat(32'h30000000, 3));
        end

        // Word 0 after the out-of-range burst: untouched with DECERR, else wrapped beat 2
        do_read("oor_w0", 32'h0, 1, BURST_INCR, 1'b0, 9'h55, d0);
        chk("oor_word0", d0, DEC ? pat(32'h50000000, 0) : pat(32'h60000000, 2));

        // Byte strobes
        do_write(32'h7D00, 0, BURST_INCR, 32'hFFFFFFFF, {SB{1'b1}}, 0, 9'h1, r_b, r_id);
        do_write(32'h7D00, 0, BURST_INCR, 32'h00000000, SB'(4'hF), 0, 9'h2, r_b, r_id);
        chk("strb_bresp", r_b, RESP_OKAY);
        do_read("strb", 32'h7D00, 0, BURST_INCR, 1'b0, 9'h3, d0);
        chk("strb_value", d0, {{(DATA_W-32){1'b1}}, 32'h0});

        // Reset mid-operation: a write burst left open and a read stalled on beat 5
        awid = 9'h7; awaddr = 32'h5000; awlen = 8'd15; awburst = BURST_INCR; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wdata = '0; wstrb = {SB{1'b1}}; wlast = 1'b0; wvalid = 1'b1;
        repeat (2) @(negedge clk);
        wvalid = 1'b0;
        arid = 9'h8; araddr = 32'h1000; arlen = 8'd15; arburst = BURST_INCR; arvalid = 1'b1;
        rready = 1'b1;
        t = 0;
        while (!arready && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        arvalid = 1'b0;
        t = 0; beats = 0;
        while (t < 200) begin
            if (rvalid && beats == 4) break;
            if (rvalid) beats++;
            @(negedge clk);
            t++;
        end
        chk("mid_reached_beat5", 32'(beats), 32'd4);
        rst = 1'b1;
        #1;
        chk("mid_rvalid_now", rvalid, 1'b0);
        chk("mid_rlast_now", rlast, 1'b0);
        repeat (2) @(negedge clk);
        chk("mid_wr_beats", wr_beats, 32'd0);
        chk("mid_rd_beats", rd_beats, 32'd0);
        chk("mid_wready", wready, 1'b0);
        rready = 1'b0; bready = 1'b1;
        exp_wr = 0; exp_rd = 0;
        rst = 1'b0;
        #1;
        chk("mid_post_awready", awready, 1'b1);
        chk("mid_post_arready", arready, 1'b1);
        seen = 1'b0;
        rready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bvalid || rvalid) seen = 1'b1;
        end
        chk("mid_no_stale_resp", seen, 1'b0);
        rready = 1'b0; bready = 1'b0;
        do_write(32'h6000, 3, BURST_INCR, 32'h77000000, {SB{1'b1}}, 3, 9'h9, r_b, r_id);
        chk("mid_new_bresp", r_b, RESP_OKAY);
        do_read("mid_new", 32'h6000, 3, BURST_INCR, 1'b0, 9'hA, d0);
        chk("mid_new_d0", d0, pat(32'h77000000, 0));
        do_read("mid_keep", 32'h1000, 15, BURST_INCR, 1'b0, 9'hB, d0);
        chk("mid_keep_d0", d0, pat(32'h10000000, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
